// File: rtl/fp_addsub_normalize_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_normalize_pipe_if
// Purpose  : Handshake and data bundle for the FP add/sub normalisation stage.
//            It carries the execute-stage beat in and the rounding-stage beat out.
//            master = upstream/downstream environment, slave = the stage itself.
// Revision : 1.0 - initial release
// ============================================================================
interface fp_addsub_normalize_pipe_if #(
  parameter int EW = 8,
  parameter int FW = 23
);
  // Upstream side
  logic          InValid;
  logic          InReady;
  logic [FW+2:0] Sum;
  logic          PSgn;
  logic          Opr;
  logic [EW-1:0] Emax;
  logic          G;
  logic          PS;
  // Downstream side
  logic          OutValid;
  logic          OutReady;
  logic [FW-1:0] NormF;
  logic [EW-1:0] NormE;
  logic          Sgn;
  logic          Grd;
  logic          Stk;
  logic          ZeroRes;
  logic          Ovf;
  logic          Unf;

  modport master (
    output InValid, Sum, PSgn, Opr, Emax, G, PS, OutReady,
    input  InReady, OutValid, NormF, NormE, Sgn, Grd, Stk, ZeroRes, Ovf, Unf
  );

  modport slave (
    input  InValid, Sum, PSgn, Opr, Emax, G, PS, OutReady,
    output InReady, OutValid, NormF, NormE, Sgn, Grd, Stk, ZeroRes, Ovf, Unf
  );
endinterface
`default_nettype wire

// File: rtl/fp_addsub_normalize_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_normalize_pipe
// Purpose  : Two-stage normalisation after the FP add/sub mantissa adder.
//            S1 registers the beat and leading-one detects the sum.
//            S2 shifts, adjusts the exponent and raises zero/ovf/unf flags.
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_normalize_pipe #(
  parameter int EW = 8,
  parameter int FW = 23
) (
  input  logic clk,
  input  logic rst,
  fp_addsub_normalize_pipe_if.slave io
);

  // Shift amount reaches FW+2 when only the guard bit is left.
  localparam int DW = $clog2(FW + 3);
  localparam int CW = (EW > DW) ? EW : DW;
  localparam int WW = FW + 2;

  // ---------------- handshake ----------------
  logic s1v_q;
  logic s2v_q;
  logic s1_rdy;
  logic s2_rdy;
  logic acc;

  assign s2_rdy      = ~s2v_q | io.OutReady;
  assign s1_rdy      = ~s1v_q | s2_rdy;
  assign acc         = io.InValid & s1_rdy;
  assign io.InReady  = s1_rdy;
  assign io.OutValid = s2v_q;

  // ---------------- S1 combinational ----------------
  logic [FW+2:0] v_d;
  logic [DW-1:0] dsh_d;

  // Subtraction never produces a carry, so the carry column is masked off.
  assign v_d = io.Opr ? {1'b0, io.Sum[FW+1:0]} : io.Sum;

  // Leading-one detect on V[FW+1:0]; an all-zero field yields FW+2 so the
  // guard bit alone would be shifted into the hidden position.
  always_comb begin
    dsh_d = DW'(FW + 2);
    for (int i = 0; i <= FW + 1; i++) begin
      if (v_d[i]) dsh_d = DW'(FW + 1 - i);
    end
  end

  // ---------------- S1 registers ----------------
  logic [FW+2:0] v_q;
  logic [DW-1:0] dsh_q;
  logic          psgn_q;
  logic          opr_q;
  logic [EW-1:0] emax_q;
  logic          g_q;
  logic          ps_q;

  // Capture an accepted beat; valid follows whenever S1 may advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1v_q  <= 1'b0;
      v_q    <= '0;
      dsh_q  <= '0;
      psgn_q <= 1'b0;
      opr_q  <= 1'b0;
      emax_q <= '0;
      g_q    <= 1'b0;
      ps_q   <= 1'b0;
    end else begin
      if (s1_rdy) s1v_q <= io.InValid;
      if (acc) begin
        v_q    <= v_d;
        dsh_q  <= dsh_d;
        psgn_q <= io.PSgn;
        opr_q  <= io.Opr;
        emax_q <= io.Emax;
        g_q    <= io.G;
        ps_q   <= io.PS;
      end
    end
  end

  // ---------------- S2 combinational ----------------
  logic [EW-1:0] einc;
  logic [WW-1:0] wsh;
  logic [CW-1:0] d_ext;
  logic [CW-1:0] e_ext;
  logic [FW-1:0] normf_d;
  logic [EW-1:0] norme_d;
  logic          sgn_d;
  logic          grd_d;
  logic          stk_d;
  logic          zero_d;
  logic          ovf_d;
  logic          unf_d;

  assign einc  = emax_q + EW'(1);
  assign d_ext = CW'(dsh_q);
  assign e_ext = CW'(emax_q);
  // Hidden bit lands in the dropped MSB, so only the lower FW+2 bits are kept.
  assign wsh   = WW'({v_q[FW+1:0], g_q} << dsh_q);

  // Classify the beat (carry / zero / underflow / normal) and build outputs.
  always_comb begin
    normf_d = '0;
    norme_d = '0;
    sgn_d   = psgn_q;
    grd_d   = 1'b0;
    stk_d   = 1'b0;
    zero_d  = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (v_q[FW+2] && !opr_q) begin
      norme_d = einc;
      if (&einc) begin
        ovf_d = 1'b1;
      end else begin
        normf_d = v_q[FW+1:2];
        grd_d   = v_q[1];
        stk_d   = v_q[0] | g_q | ps_q;
      end
    end else if ((v_q == '0) && !g_q) begin
      zero_d = 1'b1;
      sgn_d  = opr_q ? 1'b0 : psgn_q;
    end else if (d_ext >= e_ext) begin
      unf_d = 1'b1;
    end else begin
      normf_d = wsh[FW+1:2];
      grd_d   = wsh[1];
      stk_d   = wsh[0] | ps_q;
      norme_d = EW'(e_ext - d_ext);
    end
  end

  // ---------------- S2 registers ----------------
  logic [FW-1:0] normf_q;
  logic [EW-1:0] norme_q;
  logic          sgn_q;
  logic          grd_q;
  logic          stk_q;
  logic          zero_q;
  logic          ovf_q;
  logic          unf_q;

  // Load S2 only when it advances so outputs hold steady under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2v_q   <= 1'b0;
      normf_q <= '0;
      norme_q <= '0;
      sgn_q   <= 1'b0;
      grd_q   <= 1'b0;
      stk_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (s2_rdy) begin
      s2v_q <= s1v_q;
      if (s1v_q) begin
        normf_q <= normf_d;
        norme_q <= norme_d;
        sgn_q   <= sgn_d;
        grd_q   <= grd_d;
        stk_q   <= stk_d;
        zero_q  <= zero_d;
        ovf_q   <= ovf_d;
        unf_q   <= unf_d;
      end
    end
  end

  assign io.NormF   = normf_q;
  assign io.NormE   = norme_q;
  assign io.Sgn     = sgn_q;
  assign io.Grd     = grd_q;
  assign io.Stk     = stk_q;
  assign io.ZeroRes = zero_q;
  assign io.Ovf     = ovf_q;
  assign io.Unf     = unf_q;

endmodule
`default_nettype wire

// File: doc/fp_addsub_normalize_pipe.md
Name: fp_addsub_normalize_pipe

Overview:
- Two-stage pipelined normalisation stage directly downstream of the FP add/sub mantissa execute stage.
- Consumes the raw mantissa sum, result sign, effective operation, larger exponent and guard/pre-sticky bits.
- Leading-one detects, shifts, adjusts the exponent and flags zero/overflow/underflow.
- Feeds the rounding stage over a valid/ready handshake.

Parameters:
- EW, 8, exponent width.
- FW, 23, stored fraction width; Sum width is FW+3.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- InValid  in  1  input beat valid
- InReady  out  1  stage can accept a beat
- Sum  in  FW+3  execute-stage sum; bit FW+2 = carry position, bit FW+1 = hidden-one position
- PSgn  in  1  pre-normalisation result sign
- Opr  in  1  effective operation (0 add, 1 sub)
- Emax  in  EW  larger operand exponent (biased, always < 2^EW-1)
- G  in  1  guard bit from alignment
- PS  in  1  pre-sticky bit from alignment
- OutValid  out  1  output beat valid
- OutReady  in  1  downstream accepts
- NormF  out  FW  normalised fraction, hidden bit dropped
- NormE  out  EW  adjusted exponent
- Sgn  out  1  result sign
- Grd  out  1  guard bit for rounding
- Stk  out  1  sticky bit for rounding
- ZeroRes  out  1  exact zero result
- Ovf  out  1  exponent overflow (result is infinity)
- Unf  out  1  exponent underflow (flushed to zero)

Behaviour:
- Reset: all pipeline valids 0; OutValid=0, InReady=1; all data outputs 0. Reset mid-flight discards in-flight beats immediately (asynchronous clear).
- Pipeline: S1 and S2 registers.
  - Beat accepted when InValid&InReady.
  - Sk advances when Sk empty or the next stage accepts.
  - InReady = ~S1v | (S2 advancing).
  - OutValid = S2v; data holds stable while OutValid&~OutReady.
  - Latency 2 cycles, throughput 1/cycle; no drops or reorders.
- S1: register inputs; form V = Opr ? {0,Sum[FW+1:0]} : Sum. Sum[FW+2] is ignored on subtraction. Compute the leading-one index k of V[FW+1:0] (priority encoder) and register d = FW+1-k.
- S2 (shift/adjust), with W = {V[FW+1:0],G}:
  - Carry case, V[FW+2]=1 and Opr=0:
    - NormF=V[FW+1:2], Grd=V[1], Stk=V[0]|G|PS, NormE=Emax+1.
    - If Emax+1 = 2^EW-1: Ovf=1, NormF=0, Grd=0, Stk=0.
  - Zero case, V=0 and G=0:
    - ZeroRes=1, NormE=0, NormF=0, Grd=0, Stk=0.
    - Sgn=0 if Opr=1 (x−x=+0); Sgn=PSgn if Opr=0.
  - Underflow, d >= Emax:
    - Unf=1, NormE=0, NormF=0, Grd=0, Stk=0, Sgn=PSgn.
  - Otherwise:
    - W'=W<<d, zero-filled.
    - NormF=W'[FW+1:2], Grd=W'[1], Stk=W'[0]|PS, NormE=Emax-d.
  - V=0 with G=1 falls into the left-shift case (d=FW+1 then shift one more); for the design it is treated as underflow if Emax <= FW+2.
- In all non-zero cases Sgn=PSgn.
- Flags are mutually exclusive; at most one of ZeroRes/Ovf/Unf is set.

Test Plan:
- Sum=26'h2000000, Opr=0, Emax=127, G=PS=0 -> two cycles later OutValid=1, NormF=0, NormE=128, Grd=0, Stk=0, no flags.
- Sum=26'h1000001, Opr=0, Emax=127, PS=1 -> NormF=0, NormE=127, Grd=1, Stk=1.
- Opr=1, Sum=26'h2200000 (bit25 ignored), Emax=130 -> d=3, NormE=127, NormF=0, Sgn=PSgn.
- Opr=1, Sum=0, G=PS=0, PSgn=1 -> ZeroRes=1, Sgn=0, NormE=0. Separately, Opr=1, Sum=26'h0000100, Emax=10 -> Unf=1, NormF=0, NormE=0.
- Opr=0, Sum=26'h2000000, Emax=254 -> Ovf=1, NormE=255, NormF=0.
- Backpressure: 4 back-to-back beats with OutReady=0 for 5 cycles -> InReady low after 2 accepted; release -> all 4 emerge in order, none lost. Assert rst with 2 beats in flight -> OutValid=0 within the same cycle, InReady=1.
